// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;

    // Word depth for a given byte-address width.
    function automatic int unsigned imem_depth(input int unsigned ins_address);
        return 32'd1 << (ins_address - 32'd2);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streaming program loader: session FSM, write pointer, word counter and handshake.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned AW     = 7,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic [AW-1:0]     ld_base,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              busy,
    output logic              ld_done,
    output logic [AW:0]       ld_count,
    output logic              we,
    output logic [AW-1:0]     waddr,
    output logic [DATA_W-1:0] wdata
);

    localparam int unsigned DEPTH = 32'd1 << AW;
    localparam int unsigned CW    = AW + 1;

    ld_state_t     state;
    logic [AW-1:0] wr_ptr;
    logic          accept;

    // ld_ready is high exactly while in LOAD, so it doubles as the state qualifier.
    assign accept = ld_valid && ld_ready;

    // The write happens on the same edge the word is accepted so a reset on the
    // following edge cannot drop it.
    assign we    = accept;
    assign waddr = wr_ptr;
    assign wdata = ld_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            ld_count <= '0;
            ld_ready <= 1'b0;
            busy     <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_start) begin
                        state    <= LOAD;
                        wr_ptr   <= ld_base;
                        ld_count <= '0;
                        ld_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        if (ld_count != CW'(DEPTH)) begin
                            ld_count <= ld_count + CW'(1);
                        end
                        if (ld_last) begin
                            state    <= DONE;
                            ld_ready <= 1'b0;
                            ld_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    ld_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/imem_loadable.sv
// Synchronous-read instruction memory with stall/flush, misalignment flag and run-time loader.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int unsigned       INS_ADDRESS = 9,
    parameter int unsigned       DATA_W      = 32,
    parameter logic [DATA_W-1:0] NOP_INSN    = DATA_W'(NOP_INSN_DEF)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INS_ADDRESS-1:0] ra,
    input  logic                   fetch_en,
    input  logic                   flush,
    output logic [DATA_W-1:0]      rd,
    output logic                   rd_valid,
    output logic                   misaligned,
    input  logic                   ld_start,
    input  logic [INS_ADDRESS-3:0] ld_base,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [DATA_W-1:0]      ld_data,
    input  logic                   ld_last,
    output logic                   busy,
    output logic                   ld_done,
    output logic [INS_ADDRESS-2:0] ld_count
);

    localparam int unsigned AW    = INS_ADDRESS - 2;
    localparam int unsigned DEPTH = imem_depth(INS_ADDRESS);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;
    logic [AW-1:0]     raddr;

    assign raddr = ra[INS_ADDRESS-1:2];

    imem_loader #(
        .AW     (AW),
        .DATA_W (DATA_W)
    ) u_loader (
        .clk      (clk),
        .reset    (reset),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .busy     (busy),
        .ld_done  (ld_done),
        .ld_count (ld_count),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata)
    );

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A session starting this edge already counts as busy so rd never shows a
    // stale fetch while busy is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd         <= NOP_INSN;
            rd_valid   <= 1'b0;
            misaligned <= 1'b0;
        end else if (busy || ld_start) begin
            rd         <= NOP_INSN;
            rd_valid   <= 1'b0;
            misaligned <= 1'b0;
        end else if (flush) begin
            rd         <= NOP_INSN;
            rd_valid   <= 1'b0;
            misaligned <= 1'b0;
        end else if (fetch_en) begin
            if (ra[1:0] != 2'b00) begin
                rd         <= NOP_INSN;
                rd_valid   <= 1'b1;
                misaligned <= 1'b1;
            end else begin
                rd         <= mem[raddr];
                rd_valid   <= 1'b1;
                misaligned <= 1'b0;
            end
        end
    end

endmodule
